// File: rtl/bus_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arb_mux
//  Purpose  : N-input arbitrated bus mux with a valid/ready output register.
//  Revision : 1.0  initial release
// ============================================================================

module bus_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] din,
    output logic [N-1:0]       ack,
    input  logic               mode,
    output logic [WIDTH-1:0]   dout,
    output logic [IDW-1:0]     dout_id,
    output logic               dout_valid,
    input  logic               ready
);

    localparam logic [IDW:0] N_EXT = (IDW+1)'(N);

    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [IDW-1:0]   id_q,    id_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   ptr_q,   ptr_d;

    logic             capture_en;
    logic             grant;
    logic [N-1:0]     rot_req;
    logic [N-1:0]     search_vec;
    logic [IDW-1:0]   offset;
    logic [IDW-1:0]   base;
    logic [IDW:0]     win_sum;
    logic [IDW-1:0]   winner;
    logic [IDW:0]     ptr_inc;
    logic [IDW-1:0]   ptr_next;
    logic [WIDTH-1:0] win_word;

    assign capture_en = !valid_q || ready;
    assign grant      = reset_n && capture_en && (|req);

    // rot_req[k] is the request of channel (ptr + k) mod N
    always_comb begin
        rot_req = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (ptr_q == IDW'(j)) begin
                    rot_req[k] = req[(j + k) % N];
                end
            end
        end
    end

    assign search_vec = mode ? rot_req : req;
    assign base       = mode ? ptr_q : '0;

    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (search_vec[k]) begin
                offset = IDW'(k);
            end
        end
    end

    assign win_sum  = {1'b0, base} + {1'b0, offset};
    assign winner   = (win_sum >= N_EXT) ? IDW'(win_sum - N_EXT) : win_sum[IDW-1:0];
    assign ptr_inc  = {1'b0, winner} + {{IDW{1'b0}}, 1'b1};
    assign ptr_next = (ptr_inc >= N_EXT) ? '0 : ptr_inc[IDW-1:0];

    always_comb begin
        ack      = '0;
        win_word = '0;
        for (int i = 0; i < N; i++) begin
            ack[i] = grant && (winner == IDW'(i));
            if (winner == IDW'(i)) begin
                win_word = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // A drain and a capture on the same edge keep the register full.
    always_comb begin
        dout_d  = dout_q;
        id_d    = id_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (grant) begin
            dout_d  = win_word;
            id_d    = winner;
            valid_d = 1'b1;
            ptr_d   = ptr_next;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            dout_q  <= dout_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_id    = id_q;
    assign dout_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arb_mux
//  Purpose  : Directed bench with a cycle-level reference model for bus_arb_mux.
//  Revision : 1.0  initial release
// ============================================================================

module tb_bus_arb_mux;

    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req;
    logic [31:0]  din_w [4];
    logic [127:0] din;
    logic [3:0]   ack;
    logic         mode;
    logic [31:0]  dout;
    logic [1:0]   dout_id;
    logic         dout_valid;
    logic         ready;

    logic [2:0]   req3;
    logic [23:0]  din3;
    logic [2:0]   ack3;
    logic [7:0]   dout3;
    logic [1:0]   id3;
    logic         valid3;

    int checks = 0;
    int errors = 0;

    int          seq4  [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0]  ack4  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int          seq3  [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0]  ack3e [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0]  word3 [6] = '{8'hA0, 8'hB1, 8'hC2, 8'hA0, 8'hB1, 8'hC2};

    always #5 clk = ~clk;

    assign din  = {din_w[3], din_w[2], din_w[1], din_w[0]};
    assign din3 = 24'hC2B1A0;

    bus_arb_mux #(.WIDTH(32), .N(4)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .din        (din),
        .ack        (ack),
        .mode       (mode),
        .dout       (dout),
        .dout_id    (dout_id),
        .dout_valid (dout_valid),
        .ready      (ready)
    );

    bus_arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req3),
        .din        (din3),
        .ack        (ack3),
        .mode       (mode),
        .dout       (dout3),
        .dout_id    (id3),
        .dout_valid (valid3),
        .ready      (ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the output register as a single slot plus a search pointer.
    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_dout  = '0;
    int          m_id    = 0;

    function automatic int mdl_winner();
        for (int k = 0; k < NCH; k++) begin
            int i;
            i = mode ? (m_ptr + k) % NCH : k;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] mdl_ack();
        int w;
        w = mdl_winner();
        if (!reset_n || (m_valid && !ready) || w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_dout  = '0;
            m_id    = 0;
        end else begin
            int w;
            w = mdl_winner();
            if (w >= 0 && (!m_valid || ready)) begin
                m_dout  = din_w[w];
                m_id    = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % NCH;
            end else if (ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cyc_ack",        ack,        mdl_ack());
        chk("cyc_dout_valid", dout_valid, m_valid);
        chk("cyc_dout",       dout,       m_dout);
        chk("cyc_dout_id",    dout_id,    m_id[1:0]);
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        req     = '0;
        req3    = '0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        req     = '0;
        req3    = '0;
        mode    = 1'b0;
        ready   = 1'b0;
        for (int i = 0; i < 4; i++) din_w[i] = 32'h0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_dout",       dout,       32'h0);
        chk("rst_dout_id",    dout_id,    2'd0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        req = 4'b1111;
        #1;
        chk("rst_ack_gated",  ack,        4'b0000);
        req = '0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single channel
        din_w[2] = 32'hDEADBEEF;
        req      = 4'b0100;
        ready    = 1'b1;
        mode     = 1'b0;
        @(negedge clk);
        chk("single_ack", ack, 4'b0100);
        @(posedge clk);
        #1;
        req = '0;
        chk("single_dout",  dout,       32'hDEADBEEF);
        chk("single_id",    dout_id,    2'd2);
        chk("single_valid", dout_valid, 1'b1);

        // round-robin fairness, with a 3-channel instance alongside
        do_reset();
        for (int i = 0; i < 4; i++) din_w[i] = 32'h1000_0000 + 32'(i);
        mode  = 1'b1;
        ready = 1'b1;
        req   = 4'b1111;
        req3  = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rr_ack",     ack,              ack4[c]);
            chk("rr_onehot",  $countones(ack),  1);
            chk("n3_ack",     ack3,             ack3e[c]);
            @(posedge clk);
            #1;
            chk("rr_id",      dout_id,          seq4[c]);
            chk("rr_valid",   dout_valid,       1'b1);
            chk("n3_id",      id3,              seq3[c]);
            chk("n3_dout",    dout3,            word3[c]);
            chk("n3_range",   id3 < 2'd3,       1'b1);
        end
        req  = '0;
        req3 = '0;

        // fixed priority, then switch to round-robin
        do_reset();
        mode  = 1'b0;
        ready = 1'b1;
        req   = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fp_ack", ack, 4'b0010);
            @(posedge clk);
            #1;
            chk("fp_id", dout_id, 2'd1);
        end
        mode = 1'b1;
        @(negedge clk);
        chk("fp_rr_ack0", ack, 4'b1000);
        @(posedge clk);
        #1;
        chk("fp_rr_id0", dout_id, 2'd3);
        @(negedge clk);
        chk("fp_rr_ack1", ack, 4'b0010);
        @(posedge clk);
        #1;
        chk("fp_rr_id1", dout_id, 2'd1);
        req = '0;

        // back-pressure
        do_reset();
        mode     = 1'b1;
        ready    = 1'b0;
        din_w[0] = 32'h12345678;
        din_w[1] = 32'hCAFE0001;
        req      = 4'b0001;
        @(negedge clk);
        chk("bp_first_ack", ack, 4'b0001);
        @(posedge clk);
        #1;
        req = 4'b0011;
        chk("bp_dout",  dout,       32'h12345678);
        chk("bp_valid", dout_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ack_held",  ack,     4'b0000);
            chk("bp_dout_held", dout,    32'h12345678);
            chk("bp_id_held",   dout_id, 2'd0);
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ack", ack, 4'b0010);
        @(posedge clk);
        #1;
        req = '0;
        chk("bp_release_id",   dout_id, 2'd1);
        chk("bp_release_dout", dout,    32'hCAFE0001);

        // asynchronous reset while a word is held
        do_reset();
        mode     = 1'b1;
        ready    = 1'b0;
        din_w[0] = 32'h12345678;
        din_w[3] = 32'hA5A50003;
        req      = 4'b0001;
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        chk("mid_valid_before", dout_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        req     = 4'b1000;
        #1;
        chk("mid_valid_cleared", dout_valid, 1'b0);
        chk("mid_dout_cleared",  dout,       32'h0);
        chk("mid_ack_gated",     ack,        4'b0000);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        chk("post_rst_ack", ack, 4'b1000);
        @(posedge clk);
        #1;
        req = '0;
        chk("post_rst_id",   dout_id, 2'd3);
        chk("post_rst_dout", dout,    32'hA5A50003);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised N-input bus multiplexer with built-in arbitration and an output register stage. It replaces the fixed 3-way 32-bit select muxes on the shared data bus. Upstream sources compete with valid/ack handshakes, one winner per cycle is chosen by fixed-priority or round-robin policy, and the winning word is held in a valid/ready output register toward the bus consumer.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (1..64)
- N, 4, number of input channels (2..8)
- IDW, derived, max(1, clog2(N)), width of channel index

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  N  per-channel data-valid
- din  in  N*WIDTH  channel i word on din[i*WIDTH +: WIDTH]
- ack  out  N  one-hot, combinational; channel i word captured at this edge when req[i]&ack[i]
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- dout  out  WIDTH  registered output word
- dout_id  out  IDW  index of channel that produced dout
- dout_valid  out  1  dout holds an untaken word
- ready  in  1  consumer accepts dout when dout_valid&ready

Reset: one clock, clk; reset_n asynchronous, active-low.

## Operation
- capture_en = !dout_valid | ready (output register empty or draining this cycle).
- Winner selection (combinational, every cycle):
  - mode=0: lowest index i with req[i]=1.
  - mode=1: first i with req[i]=1 searching ptr, ptr+1, ..., wrapping modulo N.
- ack = one-hot(winner) when capture_en and |req, else 0. ack is 0 while reset_n=0. ack never has more than one bit set.
- On a clock edge with capture (|ack): dout <= din[winner], dout_id <= winner, dout_valid <= 1, ptr <= (winner+1) mod N. ptr updates in both modes, so switching to mode=1 continues from the last winner.
- On an edge with dout_valid&ready and no capture: dout_valid <= 0; dout and dout_id keep their last value.
- While dout_valid&!ready: dout, dout_id, dout_valid and ptr held; ack=0.
- A channel holding req=1 across consecutive acks supplies one word per ack. Upstream may change din[i] only after the ack edge.
- mode is sampled combinationally and may change on any cycle. It affects only the capture in that cycle.
- ptr wrap: winner N-1 sets ptr to 0. For N not a power of two, ptr never takes values >= N.

## Timing
- Reset values: dout=0, dout_id=0, dout_valid=0, ptr=0, ack=0.
- Latency: req[i] high in cycle t with capture_en gives ack[i] in cycle t; dout_valid=1 with the word in cycle t+1.
- Throughput: with ready held 1, one word per cycle (simultaneous drain and capture on the same edge).
- Back-pressure: once dout_valid=1 and ready=0, no acks are issued until the cycle ready=1.
- Reset mid-operation: outputs clear asynchronously, the held word is dropped, and no ack is asserted. The first capture after release obeys ptr=0.
- No combinational path from ready to dout. ready→ack and req→ack are combinational, by design.

## Test plan
- Single channel (N=4, WIDTH=32): req=0100, din[2]=0xDEADBEEF, ready=1 → ack=0100 same cycle; next cycle dout=0xDEADBEEF, dout_id=2, dout_valid=1.
- Round-robin fairness: mode=1, req=1111 held, ready=1, from reset → dout_id sequence 0,1,2,3,0,1; each ack one-hot; 1 word/cycle.
- Fixed priority: mode=0, req=1010 held, ready=1 → dout_id=1 every cycle and channel 3 never acked. Switch to mode=1 after three captures → next dout_id=3, then 1.
- Back-pressure: word 0x12345678 from channel 0 valid, ready=0 for 5 cycles with req=0011 → dout and dout_id stable, ack=0 throughout. Raise ready → ack=0010 that cycle; next dout_id=1.
- Wrap with N=3 (IDW=2): mode=1, req=111 → dout_id 0,1,2,0; ptr never reaches 3.
- Reset mid-transfer: dout_valid=1, ready=0, assert reset_n=0 asynchronously between edges → dout_valid=0, dout=0, ack=0 immediately. After release with req=1000, mode=1 → dout_id=3.
